// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared constants and types for the interrupt controller
`timescale 1ns/1ps
package int_ctrl_pkg;

  localparam int N_SRC_DEF = 6;

  localparam logic [1:0] ADDR_PEND  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_MODE  = 2'd2;
  localparam logic [1:0] ADDR_INSVC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_ctrl_sync_edge.sv
// rtl/int_ctrl_sync_edge.sv - two-flop synchronizer with rising-edge detect
`timescale 1ns/1ps
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  // Two metastability flops, plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~sync_d;

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - prioritised interrupt controller presenting one-hot HWInt to CP0
`timescale 1ns/1ps
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_taken,
  input  logic             eret,
  output logic [N_SRC-1:0] hwint,
  output logic             busy
);

  logic [N_SRC-1:0] sync_lvl;
  logic [N_SRC-1:0] edge_det;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] win_onehot;
  logic [N_SRC-1:0] hwint_q;
  logic [N_SRC-1:0] hwint_next;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] take_clr;
  logic [2:0]       hw_id;
  logic             insvc_valid;
  logic [2:0]       insvc_id;
  logic             win_any;
  logic             take;
  logic             done;
  logic             wr_pend;
  logic             wr_mask;
  logic             wr_mode;
  logic             wr_eoi;
  logic             unused_wdata;
  state_t           state;
  state_t           state_next;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    sync_edge u_sync_edge (
      .clk   (clk),
      .rst   (rst),
      .din   (src[g]),
      .level (sync_lvl[g]),
      .rise  (edge_det[g])
    );
  end

  assign wr_pend = we && (addr == ADDR_PEND);
  assign wr_mask = we && (addr == ADDR_MASK);
  assign wr_mode = we && (addr == ADDR_MODE);
  assign wr_eoi  = we && (addr == ADDR_INSVC);

  assign eligible     = pend & mask;
  assign unused_wdata = ^wdata[31:N_SRC];

  // Lowest-indexed eligible source wins; src0 has the highest priority.
  always_comb begin
    win_onehot = '0;
    win_any    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i] && !win_any) begin
        win_onehot[i] = 1'b1;
        win_any       = 1'b1;
      end
    end
  end

  // Index of the source CP0 currently sees, latched into INSVC on a take.
  always_comb begin
    hw_id = 3'd0;
    for (int i = 0; i < N_SRC; i++) begin
      if (hwint_q[i]) hw_id = 3'(i);
    end
  end

  // Next state; hwint only ever shows the live winner while in REQ.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_any) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (int_taken) begin
          state_next = ST_SERVICE;
          take       = 1'b1;
        end else if (!win_any) begin
          state_next = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eret || wr_eoi) begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    hwint_next = (state_next == ST_REQ) ? win_onehot : '0;
  end

  // FSM state and the registered HWInt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      hwint_q <= '0;
    end else begin
      state   <= state_next;
      hwint_q <= hwint_next;
    end
  end

  assign w1c      = wr_pend ? wdata[N_SRC-1:0] : '0;
  assign take_clr = take ? (hwint_q & mode) : '0;

  // PEND: edge bits are sticky with W1C/take clear losing to a new edge; level bits follow the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (mode & ((pend & ~w1c & ~take_clr) | edge_det)) | (~mode & sync_lvl);
    end
  end

  // MASK and MODE bus registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
      mode <= '0;
    end else begin
      if (wr_mask) mask <= wdata[N_SRC-1:0];
      if (wr_mode) mode <= wdata[N_SRC-1:0];
    end
  end

  // INSVC records the taken source until eret or EOI.
  always_ff @(posedge clk) begin
    if (rst) begin
      insvc_valid <= 1'b0;
      insvc_id    <= 3'd0;
    end else if (take) begin
      insvc_valid <= 1'b1;
      insvc_id    <= hw_id;
    end else if (done) begin
      insvc_valid <= 1'b0;
    end
  end

  // Combinational register read, zero-extended.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_PEND:  rdata[N_SRC-1:0] = pend;
      ADDR_MASK:  rdata[N_SRC-1:0] = mask;
      ADDR_MODE:  rdata[N_SRC-1:0] = mode;
      ADDR_INSVC: rdata[3:0]       = {insvc_valid, insvc_id};
      default:    rdata            = '0;
    endcase
  end

  assign hwint = hwint_q;
  assign busy  = (state == ST_SERVICE);

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl
`timescale 1ns/1ps
module tb_int_ctrl;

  localparam int N = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  src = '0;
  logic [1:0]    addr = 2'd0;
  logic          we = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          int_taken = 1'b0;
  logic          eret = 1'b0;
  logic [N-1:0]  hwint;
  logic          busy;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int_ctrl #(.N_SRC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .src       (src),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .int_taken (int_taken),
    .eret      (eret),
    .hwint     (hwint),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp_v);
    we   = 1'b0;
    addr = a;
    #1;
    chk(tag, rdata, exp_v);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic pulse_src(input logic [N-1:0] v);
    src = v;
    tick();
    src = '0;
  endtask

  task automatic take_it();
    int_taken = 1'b1;
    tick();
    int_taken = 1'b0;
  endtask

  task automatic ret_it();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  // Reference model for the random phase: PEND sees src two samples late.
  logic [N-1:0] hist [4];
  logic [N-1:0] m_pend, m_mask, m_mode, exp_hw;

  function automatic logic [N-1:0] lowest(input logic [N-1:0] x);
    return x & (~x + 1'b1);
  endfunction

  initial begin
    logic [N-1:0] elig, rise, lvl, w1c;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk_reg("reset_pend", 2'd0, 32'h0);
    chk_reg("reset_mask", 2'd1, 32'h0);
    chk_reg("reset_mode", 2'd2, 32'h0);
    chk_reg("reset_insvc", 2'd3, 32'h0);
    chk("reset_hwint", 32'(hwint), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Basic edge interrupt on src[2]
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h3F);
    chk_reg("mask_rw", 2'd1, 32'h3F);
    take_it();
    chk("take_in_idle_ignored", 32'(busy), 32'h0);
    pulse_src(6'h04);
    tick();
    chk_reg("pend_latency_2", 2'd0, 32'h0);
    tick();
    chk_reg("pend_latency_3", 2'd0, 32'h04);
    chk("hwint_before_req", 32'(hwint), 32'h0);
    tick();
    chk("hwint_src2", 32'(hwint), 32'h04);
    take_it();
    chk_reg("insvc_src2", 2'd3, 32'hA);
    chk_reg("pend_cleared_take", 2'd0, 32'h0);
    chk("hwint_service", 32'(hwint), 32'h0);
    chk("busy_service", 32'(busy), 32'h1);
    ret_it();
    chk("busy_after_eret", 32'(busy), 32'h0);

    // Two simultaneous edges, priority and EOI
    pulse_src(6'h12);
    tick(); tick();
    chk_reg("pend_two", 2'd0, 32'h12);
    tick();
    chk("hwint_prio", 32'(hwint), 32'h02);
    take_it();
    chk_reg("insvc_src1", 2'd3, 32'h9);
    chk_reg("pend_after_take1", 2'd0, 32'h10);
    wr(2'd3, 32'h0);
    chk("busy_after_eoi", 32'(busy), 32'h0);
    tick();
    chk("hwint_src4", 32'(hwint), 32'h10);
    take_it();
    ret_it();

    // Level mode on src[3]
    wr(2'd2, 32'h37);
    wr(2'd1, 32'h08);
    src = 6'h08;
    tick(); tick(); tick();
    chk_reg("level_pend", 2'd0, 32'h08);
    tick();
    chk("level_hwint", 32'(hwint), 32'h08);
    wr(2'd0, 32'h08);
    chk_reg("level_w1c_ignored", 2'd0, 32'h08);
    take_it();
    chk_reg("level_insvc", 2'd3, 32'hB);
    chk_reg("level_pend_after_take", 2'd0, 32'h08);
    ret_it();
    tick();
    chk("level_hwint_again", 32'(hwint), 32'h08);
    src = 6'h00;
    tick(); tick(); tick();
    chk_reg("level_pend_drop", 2'd0, 32'h0);
    tick();
    chk("level_hwint_drop", 32'(hwint), 32'h0);

    // Masking while in REQ
    wr(2'd2, 32'h3F);
    wr(2'd1, 32'h3F);
    pulse_src(6'h04);
    tick(); tick(); tick();
    chk("mask_req_hwint", 32'(hwint), 32'h04);
    wr(2'd1, 32'h0);
    tick();
    chk("mask_off_hwint", 32'(hwint), 32'h0);
    wr(2'd1, 32'h3F);
    tick();
    chk("mask_on_hwint", 32'(hwint), 32'h04);
    take_it();
    wr(2'd3, 32'h0);
    tick();

    // W1C racing a new edge on src[0]
    pulse_src(6'h01);
    tick();
    wr(2'd0, 32'h01);
    chk_reg("set_beats_w1c", 2'd0, 32'h01);
    wr(2'd0, 32'h01);
    chk_reg("w1c_clears", 2'd0, 32'h0);
    tick(); tick();
    chk("hwint_after_w1c", 32'(hwint), 32'h0);

    // Reset during SERVICE
    pulse_src(6'h20);
    tick(); tick(); tick();
    take_it();
    chk("busy_before_rst", 32'(busy), 32'h1);
    pulse_src(6'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reg("rst_pend", 2'd0, 32'h0);
    chk_reg("rst_mask", 2'd1, 32'h0);
    chk_reg("rst_mode", 2'd2, 32'h0);
    chk_reg("rst_insvc", 2'd3, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hwint", 32'(hwint), 32'h0);
    wr(2'd1, 32'h3F);
    wr(2'd2, 32'h3F);
    tick();
    chk_reg("rst_no_stale_edge", 2'd0, 32'h0);

    // Random phase against the reference model (no takes)
    rst = 1'b1;
    src = '0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) hist[k] = '0;
    m_pend = '0; m_mask = '0; m_mode = '0; exp_hw = '0;
    for (int c = 0; c < 400; c++) begin
      chk_reg("rand_pend", 2'd0, 32'(m_pend));
      chk("rand_hwint", 32'(hwint), 32'(exp_hw));
      src   = N'($urandom);
      we    = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom_range(0, 2));
      wdata = $urandom;
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = src;
      rise = hist[2] & ~hist[3];
      lvl  = hist[2];
      elig = m_pend & m_mask;
      exp_hw = lowest(elig);
      w1c = (we && addr == 2'd0) ? wdata[N-1:0] : '0;
      m_pend = (m_mode & ((m_pend & ~w1c) | rise)) | (~m_mode & lvl);
      if (we && addr == 2'd1) m_mask = wdata[N-1:0];
      if (we && addr == 2'd2) m_mode = wdata[N-1:0];
      tick();
    end
    we = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
